time_counter: RTL



---
 rtl/time_counter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/time_counter.sv
// Time-of-day counter: 1 s prescaler plus hh:mm:ss kept natively in packed BCD, with per-field adjust.
// Optional auto-repeat of held adjust bits when TIME_COUNTER_AUTO_REPEAT_EN is defined.
module time_counter #(
  parameter int TICK_DIV      = 50_000_000,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [2:0]  cnt_inc,
  input  logic [2:0]  cnt_dec,
  input  logic        run,
  output logic [23:0] Data,
  output logic        full_flag,
  output logic        sec_tick
);

  localparam int PW = $clog2(TICK_DIV);

  // Field 0 = seconds, 1 = minutes, 2 = hours; each is two BCD digits.
  logic [2:0][7:0] field_q, field_d, field_adj, field_tick, field_max;
  logic [PW-1:0]   presc_q, presc_d;
  logic [2:0]      inc_prev_q, dec_prev_q;
  logic            armed_q, armed_d;
  logic            full_q, full_d;
  logic            tick_q, tick_d;
  logic            tick;
  logic [2:0]      inc_rep, dec_rep;
  logic [2:0]      inc_step, dec_step, inc_eff, dec_eff;
  logic            adjust;
  logic            sec_wrap, min_wrap, midnight;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
    logic [7:0] r;
    if (v == vmax)          r = 8'h00;
    else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                    r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] vmax);
    logic [7:0] r;
    if (v == 8'h00)          r = vmax;
    else if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
    else                     r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  assign field_max = {8'h23, 8'h59, 8'h59};
  assign tick      = (presc_q == PW'(TICK_DIV - 1));

`ifdef TIME_COUNTER_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  logic [RW-1:0] rep_q, rep_d;
  logic          rep_fire;

  // Any change of the adjust inputs (or all released) restarts the hold count.
  always_comb begin
    rep_d    = '0;
    rep_fire = 1'b0;
    if (({cnt_inc, cnt_dec} == {inc_prev_q, dec_prev_q}) && (|{cnt_inc, cnt_dec})) begin
      rep_d = rep_q + RW'(1);
      if (rep_d == RW'(REPEAT_DELAY + REPEAT_PERIOD)) begin
        rep_fire = 1'b1;
        rep_d    = RW'(REPEAT_DELAY);
      end else if (rep_d == RW'(REPEAT_DELAY)) begin
        rep_fire = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) rep_q <= '0;
    else          rep_q <= rep_d;
  end

  assign inc_rep = rep_fire ? cnt_inc : 3'b000;
  assign dec_rep = rep_fire ? cnt_dec : 3'b000;
`else
  logic unused_repeat;
  assign unused_repeat = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign inc_rep       = 3'b000;
  assign dec_rep       = 3'b000;
`endif

  // The first edge after reset only loads the previous-value registers, so a held bit cannot step.
  assign inc_step = armed_q ? ((cnt_inc & ~inc_prev_q) | inc_rep) : 3'b000;
  assign dec_step = armed_q ? ((cnt_dec & ~dec_prev_q) | dec_rep) : 3'b000;
  assign inc_eff  = inc_step & ~dec_step;
  assign dec_eff  = dec_step & ~inc_step;
  assign adjust   = |{inc_eff, dec_eff};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_field
      assign field_adj[gi] = inc_eff[gi] ? bcd_inc(field_q[gi], field_max[gi]) :
                             dec_eff[gi] ? bcd_dec(field_q[gi], field_max[gi]) :
                             field_q[gi];
    end
  endgenerate

  assign sec_wrap = (field_q[0] == 8'h59);
  assign min_wrap = (field_q[1] == 8'h59);
  assign midnight = (field_q == {8'h23, 8'h59, 8'h59});

  always_comb begin
    field_tick[0] = bcd_inc(field_q[0], field_max[0]);
    field_tick[1] = sec_wrap ? bcd_inc(field_q[1], field_max[1]) : field_q[1];
    field_tick[2] = (sec_wrap && min_wrap) ? bcd_inc(field_q[2], field_max[2]) : field_q[2];
  end

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    armed_d = 1'b1;
    tick_d  = tick;
    field_d = field_q;
    full_d  = 1'b0;
    // Adjust steps take priority; a coinciding tick is dropped.
    if (adjust) begin
      field_d = field_adj;
    end else if (tick && run) begin
      field_d = field_tick;
      full_d  = midnight;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      presc_q    <= '0;
      inc_prev_q <= 3'b000;
      dec_prev_q <= 3'b000;
      armed_q    <= 1'b0;
      field_q    <= '0;
      full_q     <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      inc_prev_q <= cnt_inc;
      dec_prev_q <= cnt_dec;
      armed_q    <= armed_d;
      field_q    <= field_d;
      full_q     <= full_d;
      tick_q     <= tick_d;
    end
  end

  assign Data      = field_q;
  assign full_flag = full_q;
  assign sec_tick  = tick_q;

endmodule
